// File: rtl/tnkiii_pkg.sv
// Shared definitions for the TNK-III video register write path:
// register addresses, FSM state type and the address-to-strobe decode.
package tnkiii_pkg;

    localparam logic [2:0] REG_MSB  = 3'd0;
    localparam logic [2:0] REG_FSY  = 3'd1;
    localparam logic [2:0] REG_FSX  = 3'd2;
    localparam logic [2:0] REG_BSY  = 3'd3;
    localparam logic [2:0] REG_BSX  = 3'd4;
    localparam logic [2:0] REG_COIN = 3'd5;

    localparam int unsigned NUM_STROBES = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_ACK    = 2'd3
    } regwr_state_e;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_e;

    // One-hot write-enable for a register address; addresses 6 and 7 select nothing.
    function automatic logic [NUM_STROBES-1:0] decode_strobe(input logic [2:0] addr);
        logic [NUM_STROBES-1:0] onehot;
        onehot = '0;
        case (addr)
            REG_MSB:  onehot[0] = 1'b1;
            REG_FSY:  onehot[1] = 1'b1;
            REG_FSX:  onehot[2] = 1'b1;
            REG_BSY:  onehot[3] = 1'b1;
            REG_BSX:  onehot[4] = 1'b1;
            REG_COIN: onehot[5] = 1'b1;
            default:  onehot = '0;
        endcase
        return onehot;
    endfunction

endpackage

// File: rtl/tnkiii_rr_arb2.sv
// Two-way grant unit: round-robin between A and B, or fixed priority to A.
module tnkiii_rr_arb2
    import tnkiii_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic take,
    output logic gnt_a,
    output logic gnt_b
);

    logic favour_b;

    // Pick a winner; on a tie the pointer decides in round-robin mode, A wins otherwise.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (req_a && req_b) begin
            if (RR_EN && favour_b) begin
                gnt_b = 1'b1;
            end else begin
                gnt_a = 1'b1;
            end
        end else begin
            gnt_a = req_a;
            gnt_b = req_b;
        end
    end

    // Pointer moves only when a grant is actually taken, favouring the other side next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            favour_b <= 1'b0;
        end else if (take && (gnt_a || gnt_b)) begin
            favour_b <= gnt_a;
        end
    end

endmodule

// File: rtl/tnkiii_regwr_arbiter.sv
// Arbitrates main-CPU (A) and sub-CPU (B) register writes onto the video
// register bank: data is presented one cycle ahead of a single write strobe.
module tnkiii_regwr_arbiter
    import tnkiii_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       VIDEO_RSTn,
    input  logic       A_REQ,
    input  logic [2:0] A_ADDR,
    input  logic [7:0] A_DATA,
    output logic       A_ACK,
    input  logic       B_REQ,
    input  logic [2:0] B_ADDR,
    input  logic [7:0] B_DATA,
    output logic       B_ACK,
    output logic [7:0] VD_out,
    output logic       MSB,
    output logic       FSY,
    output logic       FSX,
    output logic       BSY,
    output logic       BSX,
    output logic       COIN_COUNTERS,
    output logic       BUSY
);

    logic                   rst_sync_n;
    regwr_state_e           state;
    regwr_state_e           state_nxt;
    owner_e                 owner;
    logic [2:0]             hold_addr;
    logic [7:0]             hold_data;
    logic [NUM_STROBES-1:0] strobe_q;
    logic                   req_a_ok;
    logic                   req_b_ok;
    logic                   gnt_a;
    logic                   gnt_b;
    logic                   take;
    logic                   grant;
    logic                   owner_req;

    // Reset asserts immediately but releases on a clock edge, so the FSM leaves reset cleanly.
    always_ff @(posedge clk or negedge VIDEO_RSTn) begin
        if (!VIDEO_RSTn) begin
            rst_sync_n <= 1'b0;
        end else begin
            rst_sync_n <= 1'b1;
        end
    end

    assign req_a_ok  = A_REQ && !A_ACK;
    assign req_b_ok  = B_REQ && !B_ACK;
    assign take      = (state == ST_IDLE);
    assign grant     = take && (gnt_a || gnt_b);
    assign owner_req = (owner == OWNER_B) ? B_REQ : A_REQ;

    tnkiii_rr_arb2 #(
        .RR_EN (RR_EN)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_sync_n),
        .req_a (req_a_ok),
        .req_b (req_b_ok),
        .take  (take),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: fixed SETUP/STROBE sequence, then hold ACK until the owner drops its request.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (grant) state_nxt = ST_SETUP;
            ST_SETUP:  state_nxt = ST_STROBE;
            ST_STROBE: state_nxt = ST_ACK;
            ST_ACK:    if (!owner_req) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Capture the winner's address and data at grant; later bus changes are ignored.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            owner     <= OWNER_A;
            hold_addr <= '0;
            hold_data <= '0;
        end else if (grant) begin
            owner     <= gnt_b ? OWNER_B : OWNER_A;
            hold_addr <= gnt_b ? B_ADDR : A_ADDR;
            hold_data <= gnt_b ? B_DATA : A_DATA;
        end
    end

    // Strobe fires in the cycle after SETUP, decoded from the held address only.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            strobe_q <= '0;
        end else if (state == ST_SETUP) begin
            strobe_q <= decode_strobe(hold_addr);
        end else begin
            strobe_q <= '0;
        end
    end

    assign VD_out        = hold_data;
    assign MSB           = strobe_q[0];
    assign FSY           = strobe_q[1];
    assign FSX           = strobe_q[2];
    assign BSY           = strobe_q[3];
    assign BSX           = strobe_q[4];
    assign COIN_COUNTERS = strobe_q[5];
    assign A_ACK         = (state == ST_ACK) && (owner == OWNER_A);
    assign B_ACK         = (state == ST_ACK) && (owner == OWNER_B);
    assign BUSY          = (state != ST_IDLE);

endmodule

// File: tb/tb_tnkiii_regwr_arbiter.sv
// Directed bench for the register write arbiter: one round-robin instance and
// one fixed-priority instance share the same stimulus.
module tb_tnkiii_regwr_arbiter;

    logic       clk = 1'b0;
    logic       VIDEO_RSTn;
    logic       a_req, b_req;
    logic [2:0] a_addr, b_addr;
    logic [7:0] a_data, b_data;

    logic       a_ack, b_ack, busy;
    logic [7:0] vd;
    logic       msb, fsy, fsx, bsy, bsx, coin;
    logic [5:0] strb;

    logic       fp_a_ack, fp_b_ack, fp_busy;
    logic [7:0] fp_vd;
    logic       fp_msb, fp_fsy, fp_fsx, fp_bsy, fp_bsx, fp_coin;
    logic [5:0] fp_strb;

    int vectors = 0;
    int miscompares = 0;

    assign strb    = {coin, bsx, bsy, fsx, fsy, msb};
    assign fp_strb = {fp_coin, fp_bsx, fp_bsy, fp_fsx, fp_fsy, fp_msb};

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    tnkiii_regwr_arbiter #(.RR_EN(1'b1)) dut (
        .clk(clk), .VIDEO_RSTn(VIDEO_RSTn),
        .A_REQ(a_req), .A_ADDR(a_addr), .A_DATA(a_data), .A_ACK(a_ack),
        .B_REQ(b_req), .B_ADDR(b_addr), .B_DATA(b_data), .B_ACK(b_ack),
        .VD_out(vd), .MSB(msb), .FSY(fsy), .FSX(fsx), .BSY(bsy), .BSX(bsx),
        .COIN_COUNTERS(coin), .BUSY(busy)
    );

    tnkiii_regwr_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .VIDEO_RSTn(VIDEO_RSTn),
        .A_REQ(a_req), .A_ADDR(a_addr), .A_DATA(a_data), .A_ACK(fp_a_ack),
        .B_REQ(b_req), .B_ADDR(b_addr), .B_DATA(b_data), .B_ACK(fp_b_ack),
        .VD_out(fp_vd), .MSB(fp_msb), .FSY(fp_fsy), .FSX(fp_fsx), .BSY(fp_bsy), .BSX(fp_bsx),
        .COIN_COUNTERS(fp_coin), .BUSY(fp_busy)
    );

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ar, input logic [2:0] aa, input logic [7:0] ad,
                                 input logic br, input logic [2:0] ba, input logic [7:0] bd);
        a_req  = ar;
        a_addr = aa;
        a_data = ad;
        b_req  = br;
        b_addr = ba;
        b_data = bd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Idle both requesters, pulse reset, release it and let the release edge pass.
    task automatic resetBoth();
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
        VIDEO_RSTn = 1'b0;
        tick();
        tick();
        VIDEO_RSTn = 1'b1;
        tick();
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1);
    end

    initial begin
        // A alone, addr 0 / 0xA5, request already pending across reset release.
        applyStimulus(1'b1, 3'd0, 8'hA5, 1'b0, 3'd0, 8'h00);
        VIDEO_RSTn = 1'b0;
        tick();
        tick();
        checkOutput("rst_vd", vd, 8'h00);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_a_ack", a_ack, 1'b0);
        checkOutput("rst_b_ack", b_ack, 1'b0);
        checkOutput("rst_strb", strb, 6'h00);
        VIDEO_RSTn = 1'b1;
        tick();
        checkOutput("rel_e1_busy", busy, 1'b0);
        tick();
        checkOutput("w0_setup_busy", busy, 1'b1);
        checkOutput("w0_setup_vd", vd, 8'hA5);
        checkOutput("w0_setup_strb", strb, 6'h00);
        a_addr = 3'd3;
        a_data = 8'h3C;
        tick();
        checkOutput("w0_strobe_msb", strb, 6'h01);
        checkOutput("w0_strobe_vd", vd, 8'hA5);
        tick();
        checkOutput("w0_ack_strb", strb, 6'h00);
        checkOutput("w0_ack_a", a_ack, 1'b1);
        checkOutput("w0_ack_b", b_ack, 1'b0);
        a_req = 1'b0;
        tick();
        checkOutput("w0_idle_a_ack", a_ack, 1'b0);
        checkOutput("w0_idle_busy", busy, 1'b0);
        checkOutput("w0_idle_vd_hold", vd, 8'hA5);
        tick();
        checkOutput("w0_idle_strb", strb, 6'h00);

        // Simultaneous A and B with round-robin: A first, then B, then A favoured again.
        resetBoth();
        applyStimulus(1'b1, 3'd1, 8'h10, 1'b1, 3'd2, 8'h20);
        tick();
        checkOutput("rr_a_vd", vd, 8'h10);
        tick();
        checkOutput("rr_a_fsy", strb, 6'h02);
        tick();
        checkOutput("rr_a_ack", a_ack, 1'b1);
        checkOutput("rr_a_b_ack", b_ack, 1'b0);
        a_req = 1'b0;
        tick();
        checkOutput("rr_a_done", a_ack, 1'b0);
        checkOutput("rr_gap_busy", busy, 1'b0);
        tick();
        checkOutput("rr_b_vd", vd, 8'h20);
        tick();
        checkOutput("rr_b_fsx", strb, 6'h04);
        tick();
        checkOutput("rr_b_ack", b_ack, 1'b1);
        checkOutput("rr_b_a_ack", a_ack, 1'b0);
        b_req = 1'b0;
        tick();
        checkOutput("rr_b_done", b_ack, 1'b0);
        applyStimulus(1'b1, 3'd0, 8'h11, 1'b1, 3'd4, 8'h44);
        tick();
        checkOutput("rr_ptr_back_to_a", vd, 8'h11);

        // Fixed priority: A re-requests at once after each write, B waits until A stops.
        resetBoth();
        applyStimulus(1'b1, 3'd1, 8'h10, 1'b1, 3'd2, 8'h20);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("fp_vd_a", fp_vd, 8'h10);
            tick();
            checkOutput("fp_strb_fsy", fp_strb, 6'h02);
            tick();
            checkOutput("fp_a_ack", fp_a_ack, 1'b1);
            checkOutput("fp_b_ack", fp_b_ack, 1'b0);
            a_req = 1'b0;
            tick();
            checkOutput("fp_idle_busy", fp_busy, 1'b0);
            if (k < 2) a_req = 1'b1;
        end
        tick();
        checkOutput("fp_b_finally", fp_vd, 8'h20);

        // Unmapped address 6: data still driven, no strobe, normal handshake.
        resetBoth();
        applyStimulus(1'b1, 3'd6, 8'hFF, 1'b0, 3'd0, 8'h00);
        tick();
        checkOutput("um_vd", vd, 8'hFF);
        tick();
        checkOutput("um_no_strb", strb, 6'h00);
        checkOutput("um_vd_hold", vd, 8'hFF);
        tick();
        checkOutput("um_ack", a_ack, 1'b1);
        a_req = 1'b0;
        tick();
        checkOutput("um_ack_drop", a_ack, 1'b0);
        checkOutput("um_busy", busy, 1'b0);

        // Reset during SETUP of a BSY write: no pulse, write redone after release.
        applyStimulus(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00);
        tick();
        checkOutput("mid_setup_busy", busy, 1'b1);
        VIDEO_RSTn = 1'b0;
        #1;
        checkOutput("mid_rst_strb", strb, 6'h00);
        checkOutput("mid_rst_busy", busy, 1'b0);
        checkOutput("mid_rst_vd", vd, 8'h00);
        checkOutput("mid_rst_ack", a_ack, 1'b0);
        tick();
        checkOutput("mid_rst_strb_e1", strb, 6'h00);
        tick();
        checkOutput("mid_rst_strb_e2", strb, 6'h00);
        VIDEO_RSTn = 1'b1;
        tick();
        checkOutput("mid_rel_e1_busy", busy, 1'b0);
        tick();
        checkOutput("mid_regrant_vd", vd, 8'h5A);
        tick();
        checkOutput("mid_bsy", strb, 6'h08);
        tick();
        checkOutput("mid_ack", a_ack, 1'b1);
        a_req = 1'b0;
        tick();
        checkOutput("mid_ack_drop", a_ack, 1'b0);

        // Coin counter write with REQ held 5 extra cycles: ACK stays, single strobe.
        applyStimulus(1'b1, 3'd5, 8'h77, 1'b0, 3'd0, 8'h00);
        tick();
        checkOutput("coin_vd", vd, 8'h77);
        tick();
        checkOutput("coin_strb", strb, 6'h20);
        tick();
        checkOutput("coin_ack", a_ack, 1'b1);
        checkOutput("coin_strb_off", strb, 6'h00);
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("coin_hold_ack", a_ack, 1'b1);
            checkOutput("coin_hold_strb", strb, 6'h00);
        end
        a_req = 1'b0;
        tick();
        checkOutput("coin_ack_drop", a_ack, 1'b0);
        checkOutput("coin_busy_drop", busy, 1'b0);
        tick();
        checkOutput("coin_no_repeat", strb, 6'h00);
        checkOutput("coin_still_idle", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
